// File: rtl/piso_tx_nbit.sv
// Parallel-in serial-out transmitter: accepts an N-bit word over valid/ready
// and shifts it out one bit per clock with frame and end-of-word qualifiers.
module piso_tx_nbit #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset_al_in,
    input  logic [N-1:0] data_in,
    input  logic         valid_in,
    output logic         ready_out,
    output logic         q_out,
    output logic         frame_out,
    output logic         done_out
);

    localparam int             CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [N-1:0]  r_shift;
    logic [N-1:0]  w_shift_nxt;
    logic          r_q;
    logic          r_frame;
    logic          r_done;
    logic          w_last;
    logic          w_accept;

    // The bit on the wire always sits at the head of the shift register.
    function automatic logic [N-1:0] advance(input logic [N-1:0] s);
        if (MSB_FIRST) begin
            return {s[N-2:0], 1'b0};
        end
        return {1'b0, s[N-1:1]};
    endfunction

    function automatic logic head(input logic [N-1:0] s);
        return MSB_FIRST ? s[N-1] : s[0];
    endfunction

    assign w_last    = (r_state == SHIFT) && (r_cnt == LAST);
    assign ready_out = (r_state == IDLE) || w_last;
    assign w_accept  = valid_in && ready_out;

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = data_in;
                end
            end
            SHIFT: begin
                // A new word can only be accepted on the last bit, giving a gapless stream.
                if (w_accept) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = data_in;
                end else if (w_last) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_shift_nxt = advance(r_shift);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_shift_nxt = '0;
            end
        endcase
    end

    // Serial outputs come straight from flops so they cannot glitch.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_q     <= 1'b0;
            r_frame <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_q     <= (w_state_nxt == SHIFT) ? head(w_shift_nxt) : 1'b0;
            r_frame <= (w_state_nxt == SHIFT);
            r_done  <= (w_state_nxt == SHIFT) && (w_cnt_nxt == LAST);
        end
    end

    assign q_out     = r_q;
    assign frame_out = r_frame;
    assign done_out  = r_done;

endmodule

// File: tb/tb_piso_tx_nbit.sv
// Bench for piso_tx_nbit: an N=4 MSB-first and an N=8 LSB-first instance,
// table vectors, hand-written corner sequences and a queue-based random model.
module tb_piso_tx_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] d4;
    logic       v4, rdy4, q4, f4, dn4;
    logic [7:0] d8;
    logic       v8, rdy8, q8, f8, dn8;

    int errors = 0;
    int checks = 0;

    piso_tx_nbit #(.N(4), .MSB_FIRST(1'b1)) dut4 (
        .clk(clk), .reset_al_in(rst_n), .data_in(d4), .valid_in(v4),
        .ready_out(rdy4), .q_out(q4), .frame_out(f4), .done_out(dn4)
    );

    piso_tx_nbit #(.N(8), .MSB_FIRST(1'b0)) dut8 (
        .clk(clk), .reset_al_in(rst_n), .data_in(d8), .valid_in(v8),
        .ready_out(rdy8), .q_out(q8), .frame_out(f8), .done_out(dn8)
    );

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       r;
        logic       q;
        logic       f;
        logic       dn;
    } vec_t;

    vec_t tbl[26];

    // Reference model: each accepted word becomes a queue of {last, bit} items.
    logic [1:0] mq[2][$];
    logic [1:0] mcur[2];
    logic       mcv[2];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk4(input string nm, input logic r, input logic q, input logic f, input logic dn);
        chk({nm, ".ready"}, rdy4, r);
        chk({nm, ".q"}, q4, q);
        chk({nm, ".frame"}, f4, f);
        chk({nm, ".done"}, dn4, dn);
    endtask

    task automatic chk8(input string nm, input logic r, input logic q, input logic f, input logic dn);
        chk({nm, ".ready"}, rdy8, r);
        chk({nm, ".q"}, q8, q);
        chk({nm, ".frame"}, f8, f);
        chk({nm, ".done"}, dn8, dn);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [3:0] d, input logic r,
                                input logic q, input logic f, input logic dn);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.q = q; t.f = f; t.dn = dn;
        return t;
    endfunction

    function automatic logic m_ready(input int k);
        return !mcv[k] || mcur[k][1];
    endfunction

    task automatic m_edge(input int k, input logic v, input logic [7:0] w);
        int n;
        logic msb;
        logic b;
        n   = (k == 0) ? 4 : 8;
        msb = (k == 0);
        if (v && m_ready(k)) begin
            for (int i = 0; i < n; i++) begin
                b = msb ? w[n-1-i] : w[i];
                mq[k].push_back({(i == n - 1), b});
            end
        end
        if (mq[k].size() > 0) begin
            mcur[k] = mq[k].pop_front();
            mcv[k]  = 1'b1;
        end else begin
            mcur[k] = 2'b00;
            mcv[k]  = 1'b0;
        end
    endtask

    initial begin
        logic       exp8[8];
        logic       exp1001[4];
        logic       rv[2];
        logic [7:0] rw[2];
        logic       acc;
        logic       er, eq, ef, ed;

        exp8    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp1001 = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Single word 1011, then back-to-back 1011/0110, then busy-ignore 1100/0011.
        tbl[0]  = mk(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[2]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[3]  = mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[4]  = mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1);
        tbl[5]  = mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b1, 4'b1011, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 4'b1011, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[10] = mk(1'b1, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b1);
        tbl[11] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[13] = mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[14] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
        tbl[15] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[16] = mk(1'b1, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[17] = mk(1'b1, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[18] = mk(1'b1, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[19] = mk(1'b1, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[20] = mk(1'b1, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b1);
        tbl[21] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[22] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[23] = mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[24] = mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1);
        tbl[25] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0;
        v4 = 1'b0; d4 = 4'h0;
        v8 = 1'b0; d8 = 8'h00;

        #2;
        chk4("rst4", 1'b1, 1'b0, 1'b0, 1'b0);
        chk8("rst8", 1'b1, 1'b0, 1'b0, 1'b0);
        #11;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) begin
            chk4($sformatf("idle4[%0d]", i), 1'b1, 1'b0, 1'b0, 1'b0);
            chk8($sformatf("idle8[%0d]", i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end

        for (int i = 0; i < 26; i++) begin
            v4 = tbl[i].v;
            d4 = tbl[i].d;
            chk4($sformatf("row%0d", i), tbl[i].r, tbl[i].q, tbl[i].f, tbl[i].dn);
            tick();
        end

        // LSB-first N=8 word A5.
        v8 = 1'b1; d8 = 8'hA5;
        chk("lsb.ready0", rdy8, 1'b1);
        tick();
        v8 = 1'b0; d8 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk8($sformatf("lsb[%0d]", i), (i == 7), exp8[i], 1'b1, (i == 7));
            tick();
        end
        chk8("lsb.after", 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset asserted between edges while the second bit of 1111 is on the wire.
        v4 = 1'b1; d4 = 4'b1111;
        tick();
        v4 = 1'b0; d4 = 4'h0;
        chk4("rmw.bit1", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk4("rmw.bit2", 1'b0, 1'b1, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk4("rmw.async", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk4($sformatf("rmw.hold%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        #4;
        rst_n = 1'b1;
        tick();
        chk4("rmw.release", 1'b1, 1'b0, 1'b0, 1'b0);
        v4 = 1'b1; d4 = 4'b1001;
        tick();
        v4 = 1'b0; d4 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            chk4($sformatf("rmw.new[%0d]", i), (i == 3), exp1001[i], 1'b1, (i == 3));
            tick();
        end
        chk4("rmw.after", 1'b1, 1'b0, 1'b0, 1'b0);

        // Random traffic on both instances against the queue model.
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mcur[k] = 2'b00;
            mcv[k]  = 1'b0;
            rv[k]   = 1'b0;
            rw[k]   = 8'h00;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                er = m_ready(k);
                eq = mcv[k] && mcur[k][0];
                ef = mcv[k];
                ed = mcv[k] && mcur[k][1];
                if (k == 0) chk4($sformatf("rnd4[%0d]", cyc), er, eq, ef, ed);
                else        chk8($sformatf("rnd8[%0d]", cyc), er, eq, ef, ed);
            end
            for (int k = 0; k < 2; k++) begin
                if (!rv[k] && ($urandom_range(0, 3) != 0)) begin
                    rv[k] = 1'b1;
                    rw[k] = 8'($urandom);
                end
            end
            v4 = rv[0]; d4 = rw[0][3:0];
            v8 = rv[1]; d8 = rw[1];
            for (int k = 0; k < 2; k++) begin
                acc = rv[k] && m_ready(k);
                m_edge(k, rv[k], rw[k]);
                if (acc) rv[k] = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_tx_nbit.md
Name: piso_tx_nbit

Overview:
Parallel-in serial-out transmitter. It is the sending end of the serial bit-stream link whose receiving end is the team's shift-register chain (SISO/SIPO). It accepts an N-bit word over a valid/ready handshake and shifts it out one bit per clock. It also drives a frame qualifier and an end-of-word pulse, so a downstream SIPO can assemble words without counting on its own.

Parameters:
N, 4, word width in bits; legal range N >= 2.
MSB_FIRST, 1, 1 = transmit bit N-1 first; 0 = transmit bit 0 first.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset_al_in  input  1  asynchronous active-low reset; clears all state immediately when low.
data_in  input  N  parallel word to transmit; sampled only on an accepted handshake.
valid_in  input  1  producer has a word on data_in.
ready_out  output  1  transmitter can accept a word this cycle.
q_out  output  1  serial data bit.
frame_out  output  1  high while q_out carries a valid data bit.
done_out  output  1  one-cycle pulse coincident with the last bit of each word.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on reset_al_in.
- Reset values while reset_al_in = 0: state IDLE, ready_out = 1, q_out = 0, frame_out = 0, done_out = 0. The shift register and bit counter are cleared.
- Handshake: a word is accepted at a rising edge where valid_in = 1 and ready_out = 1. data_in is captured into the internal shift register at that edge.
- valid_in = 1 while ready_out = 0 is ignored. data_in is not sampled, and the producer must hold the word until it is accepted.
- States: IDLE and SHIFT.
- IDLE:
  - ready_out = 1, frame_out = 0, q_out = 0.
  - An accepted word moves the FSM to SHIFT with bit counter = 0.
- SHIFT:
  - frame_out = 1.
  - q_out = current bit: data[N-1-cnt] when MSB_FIRST = 1, data[cnt] when MSB_FIRST = 0.
  - The counter increments by 1 each cycle. Counter width is $clog2(N).
- Latency: the first bit appears on q_out in the cycle after the accept edge. Bits occupy exactly N consecutive cycles.
- Last bit (cnt = N-1):
  - done_out = 1 for that cycle.
  - ready_out = 1 (combinational on state and counter).
  - If a word is accepted at the end of this cycle, the counter resets to 0 and the new word's first bit follows with no gap; frame_out stays high.
  - Otherwise the FSM returns to IDLE.
- Streaming: back-to-back words give a continuous stream with frame_out held high. done_out pulses once every N cycles.
- Mid-word: ready_out = 0 in SHIFT while cnt < N-1. The word in flight is never corrupted by producer activity.
- Reset mid-operation: reset_al_in low forces the reset values immediately, asynchronously to clk. The word in flight is discarded, with no partial done_out. After release the FSM starts in IDLE.
- Outputs q_out, frame_out and done_out are glitch-free functions of registered state.

Test Plan:
- Single word, N=4, MSB_FIRST=1: release reset, then one-cycle valid_in with data_in = 4'b1011.
  -> q_out = 1,0,1,1 on cycles 1-4 after the accept. frame_out high for exactly those 4 cycles. done_out high only on cycle 4. ready_out = 0 on cycles 1-3. The block then returns to IDLE with q_out = 0.
- Back-to-back: valid_in held high with 4'b1011, then 4'b0110, accepted at the start and at cycle 4.
  -> q_out = 1,0,1,1,0,1,1,0 over 8 contiguous cycles. frame_out is never deasserted. done_out pulses on cycles 4 and 8.
- LSB first, MSB_FIRST=0, N=8: send data_in = 8'hA5.
  -> q_out = 1,0,1,0,0,1,0,1, with done_out on the 8th bit.
- Busy-ignore: accept 4'b1100. During cycles 1-3, change data_in to 4'b0011 with valid_in high.
  -> The serial output is still 1,1,0,0. The new word is accepted only at the cycle-4 edge, and its bits 0,0,1,1 follow immediately.
- Reset mid-word: accept 4'b1111 and drive reset_al_in low after bit 2, between clock edges.
  -> q_out, frame_out and done_out go to 0 at once, with no done_out pulse. After release, ready_out = 1, and a fresh 4'b1001 transmits correctly as 1,0,0,1.
- Idle hold: no valid_in for 20 cycles after reset.
  -> ready_out = 1 and q_out = frame_out = done_out = 0 throughout.
